// File: rtl/frac_dec_coef_ctrl_if.sv
// APB bus bundle between software and the fractional decimator coefficient controller.
// The master drives the request side; the slave answers with zero wait states.
interface frac_dec_coef_ctrl_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [31:0]           pwdata;
   logic [31:0]           prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/frac_dec_coef_ctrl.sv
// Coefficient controller for the fractional decimator: software loads a shadow tap bank over APB,
// and the bank is committed to the active taps only at a decimator output-phase boundary.
module frac_dec_coef_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int TAPS_NUM   = 138,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                           CLK,
   input  logic                           RST,
   frac_dec_coef_ctrl_if.slave            apb,
   input  logic                           dec_valid_i,
   output logic [TAPS_NUM*DATA_WIDTH-1:0] coef_flat_o,
   output logic                           dec_en_o,
   output logic                           dec_bypass_o,
   output logic                           swap_done_o
);

   typedef enum logic {IDLE, PENDING} swap_state_e;

   swap_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] shadow_q [TAPS_NUM];
   logic [DATA_WIDTH-1:0] active_q [TAPS_NUM];
   logic                  en_q;
   logic                  bypass_q;
   logic                  swapDone_q;
   logic [7:0]            swapCnt_q, swapCnt_d;

   logic       access;
   logic       wr;
   logic       hitCtrl;
   logic       hitStatus;
   logic       hitCoef;
   logic [7:0] coefIdx;
   logic       pending;
   logic       ctrlWr;
   logic       coefWrOk;
   logic       commit;
   logic [31:0] rdata;
   logic        unused_pwdata;

   assign access    = apb.psel & apb.penable;
   assign wr        = access & apb.pwrite;
   assign coefIdx   = apb.paddr[7:0];
   assign hitCtrl   = (apb.paddr == ADDR_WIDTH'(0));
   assign hitStatus = (apb.paddr == ADDR_WIDTH'(1));
   assign hitCoef   = (apb.paddr[ADDR_WIDTH-1:8] == (ADDR_WIDTH-8)'(1))
                      && ({1'b0, coefIdx} < 9'(TAPS_NUM));
   assign pending   = (state_q == PENDING);
   assign ctrlWr    = wr & hitCtrl;
   assign coefWrOk  = wr & hitCoef & ~pending;
   assign unused_pwdata = ^apb.pwdata[31:DATA_WIDTH];

   // A disabled decimator has no phase to protect, so a pending set commits straight away.
   assign commit = pending & (~en_q | dec_valid_i);

   always_comb begin
      state_d   = state_q;
      swapCnt_d = swapCnt_q;
      if (pending) begin
         if (commit) begin
            state_d   = IDLE;
            swapCnt_d = swapCnt_q + 8'd1;
         end
      end else if (ctrlWr && apb.pwdata[2]) begin
         state_d = PENDING;
      end
   end

   always_comb begin
      rdata = '0;
      if (access) begin
         if (hitCtrl) begin
            rdata = {29'b0, 1'b0, bypass_q, en_q};
         end else if (hitStatus) begin
            rdata = {16'b0, swapCnt_q, 7'b0, pending};
         end else if (hitCoef) begin
            rdata = {{(32-DATA_WIDTH){shadow_q[coefIdx][DATA_WIDTH-1]}}, shadow_q[coefIdx]};
         end
      end
   end

   assign apb.prdata  = rdata;
   assign apb.pready  = 1'b1;
   assign apb.pslverr = access & (~(hitCtrl | hitStatus | hitCoef) | (wr & hitCoef & pending));

   // Whole-bank copy in one edge keeps every filter output on a single coefficient set.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         en_q       <= 1'b0;
         bypass_q   <= 1'b0;
         swapDone_q <= 1'b0;
         swapCnt_q  <= '0;
         for (int k = 0; k < TAPS_NUM; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         swapCnt_q  <= swapCnt_d;
         swapDone_q <= commit;
         if (ctrlWr) begin
            en_q     <= apb.pwdata[0];
            bypass_q <= apb.pwdata[1];
         end
         if (coefWrOk) begin
            shadow_q[coefIdx] <= apb.pwdata[DATA_WIDTH-1:0];
         end
         if (commit) begin
            for (int k = 0; k < TAPS_NUM; k++) begin
               active_q[k] <= shadow_q[k];
            end
         end
      end
   end

   for (genvar k = 0; k < TAPS_NUM; k++) begin : gFlat
      assign coef_flat_o[k*DATA_WIDTH +: DATA_WIDTH] = active_q[k];
   end

   assign dec_en_o     = en_q;
   assign dec_bypass_o = bypass_q;
   assign swap_done_o  = swapDone_q;

endmodule

// File: tb/tb_frac_dec_coef_ctrl.sv
// Self-checking bench for frac_dec_coef_ctrl: APB register access, deferred and immediate
// commits, error responses, SWAP_CNT wrap and reset while a commit is pending.
module tb_frac_dec_coef_ctrl;

   localparam int DW   = 16;
   localparam int TAPS = 138;
   localparam int AW   = 9;
   localparam int FW   = TAPS * DW;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          dec_valid = 1'b0;
   logic [FW-1:0] coef_flat;
   logic          dec_en;
   logic          dec_bypass;
   logic          swap_done;

   frac_dec_coef_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   frac_dec_coef_ctrl #(
      .DATA_WIDTH(DW),
      .TAPS_NUM  (TAPS),
      .ADDR_WIDTH(AW)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .apb         (bus),
      .dec_valid_i (dec_valid),
      .coef_flat_o (coef_flat),
      .dec_en_o    (dec_en),
      .dec_bypass_o(dec_bypass),
      .swap_done_o (swap_done)
   );

   always #5 CLK = ~CLK;

   int vecCount  = 0;
   int missCount = 0;

   logic [DW-1:0] modelShadow [TAPS];
   logic [7:0]    modelCnt;
   logic [FW-1:0] modelActive;
   logic [FW-1:0] flatQ [$];
   logic [31:0]   rdQ [$];

   function automatic logic [FW-1:0] buildFlat();
      logic [FW-1:0] f;
      for (int k = 0; k < TAPS; k++) f[k*DW +: DW] = modelShadow[k];
      return f;
   endfunction

   function automatic int firstDiffTap(input logic [FW-1:0] a, input logic [FW-1:0] b);
      for (int k = 0; k < TAPS; k++) begin
         if (a[k*DW +: DW] !== b[k*DW +: DW]) return k;
      end
      return -1;
   endfunction

   function automatic logic [31:0] statusWord(input logic pend);
      return {16'h0, modelCnt, 7'h0, pend};
   endfunction

   function automatic void modelReset();
      for (int k = 0; k < TAPS; k++) modelShadow[k] = '0;
      modelActive = '0;
      modelCnt    = '0;
   endfunction

   // One full APB transfer; returns at #1 after the edge that ends the access phase.
   task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                input logic dvAccess, output logic [31:0] rdata, output logic err);
      @(posedge CLK); #1;
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = wr;
      bus.paddr   = addr;
      bus.pwdata  = wdata;
      @(posedge CLK); #1;
      bus.penable = 1'b1;
      if (dvAccess) dec_valid = 1'b1;
      @(negedge CLK);
      rdata = bus.prdata;
      err   = bus.pslverr;
      @(posedge CLK); #1;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      dec_valid   = 1'b0;
   endtask

   task automatic pulseDecValid();
      @(posedge CLK); #1;
      dec_valid = 1'b1;
      @(posedge CLK); #1;
      dec_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd, exp;
      logic        err;
      logic [AW-1:0] addrs [3];
      addrs[0] = 9'h000; addrs[1] = 9'h001; addrs[2] = 9'h100;
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      vecCount++;
      if (coef_flat !== '0) begin
         missCount++;
         $display("[TB] FAIL reset_coef: tap %0d nonzero", firstDiffTap(coef_flat, '0));
      end
      vecCount++;
      if ({dec_en, dec_bypass, swap_done} !== 3'b000) begin
         missCount++;
         $display("[TB] FAIL reset_outputs: got %b expected 000", {dec_en, dec_bypass, swap_done});
      end
      vecCount++;
      if ({bus.prdata, bus.pslverr} !== 33'h0) begin
         missCount++;
         $display("[TB] FAIL reset_apb: prdata %h pslverr %b expected 0/0", bus.prdata, bus.pslverr);
      end
      @(posedge CLK); #1;
      RST = 1'b1;
      modelReset();
      for (int i = 0; i < 3; i++) begin
         rdQ.push_back(32'h0);
         applyStimulus(1'b0, addrs[i], 32'h0, 1'b0, rd, err);
         exp = rdQ.pop_front();
         vecCount++;
         if (rd !== exp || err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_read_%h: got %h err %b expected %h err 0", addrs[i], rd, err, exp);
         end
      end
   endtask

   task automatic test_ctrl_rw();
      logic [31:0] rd, exp;
      logic        err;
      applyStimulus(1'b1, 9'h000, 32'h3, 1'b0, rd, err);
      @(negedge CLK);
      vecCount++;
      if ({dec_en, dec_bypass} !== 2'b11 || err !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL ctrl_outputs: got en/byp %b err %b expected 11 err 0", {dec_en, dec_bypass}, err);
      end
      rdQ.push_back(32'h3);
      applyStimulus(1'b0, 9'h000, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL ctrl_read: got %h expected %h", rd, exp);
      end
   endtask

   task automatic test_deferred_commit();
      logic [31:0]   rd, exp;
      logic          err;
      logic [FW-1:0] expFlat;
      applyStimulus(1'b1, 9'h100, 32'h7FFF, 1'b0, rd, err);
      modelShadow[0] = 16'h7FFF;
      applyStimulus(1'b1, 9'h100 + 9'd137, 32'h8000, 1'b0, rd, err);
      modelShadow[137] = 16'h8000;
      rdQ.push_back(32'hFFFF8000);
      applyStimulus(1'b0, 9'h100 + 9'd137, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL coef137_signext: got %h expected %h", rd, exp);
      end
      applyStimulus(1'b1, 9'h000, 32'h7, 1'b0, rd, err);
      flatQ.push_back(buildFlat());
      rdQ.push_back(statusWord(1'b1));
      applyStimulus(1'b0, 9'h001, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL status_pending: got %h expected %h", rd, exp);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         vecCount++;
         if (coef_flat !== modelActive || swap_done !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL deferred_hold_c%0d: diff tap %0d swap_done %b expected no change",
                     c, firstDiffTap(coef_flat, modelActive), swap_done);
         end
      end
      pulseDecValid();
      @(negedge CLK);
      expFlat = flatQ.pop_front();
      vecCount++;
      if (swap_done !== 1'b1 || coef_flat !== expFlat) begin
         missCount++;
         $display("[TB] FAIL deferred_commit: swap_done %b diff tap %0d expected swap_done 1 no diff",
                  swap_done, firstDiffTap(coef_flat, expFlat));
      end
      modelActive = expFlat;
      modelCnt++;
      @(negedge CLK);
      vecCount++;
      if (swap_done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL swap_done_single: got %b expected 0", swap_done);
      end
      rdQ.push_back(statusWord(1'b0));
      applyStimulus(1'b0, 9'h001, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL status_after_commit: got %h expected %h", rd, exp);
      end
   endtask

   task automatic test_immediate_commit();
      logic [31:0]   rd, exp;
      logic          err;
      logic [FW-1:0] expFlat;
      applyStimulus(1'b1, 9'h000, 32'h0, 1'b0, rd, err);
      applyStimulus(1'b1, 9'h101, 32'h1234, 1'b0, rd, err);
      modelShadow[1] = 16'h1234;
      applyStimulus(1'b1, 9'h000, 32'h4, 1'b0, rd, err);
      flatQ.push_back(buildFlat());
      @(negedge CLK);
      vecCount++;
      if (coef_flat !== modelActive || swap_done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL immediate_early: diff tap %0d swap_done %b expected old taps, 0",
                  firstDiffTap(coef_flat, modelActive), swap_done);
      end
      @(negedge CLK);
      expFlat = flatQ.pop_front();
      vecCount++;
      if (swap_done !== 1'b1 || coef_flat !== expFlat) begin
         missCount++;
         $display("[TB] FAIL immediate_commit: swap_done %b diff tap %0d expected 1 / no diff",
                  swap_done, firstDiffTap(coef_flat, expFlat));
      end
      modelActive = expFlat;
      modelCnt++;
      rdQ.push_back(statusWord(1'b0));
      applyStimulus(1'b0, 9'h001, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL immediate_status: got %h expected %h", rd, exp);
      end
   endtask

   task automatic waitCommit(input string name);
      logic          found;
      logic [FW-1:0] expFlat;
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         @(negedge CLK);
         if (swap_done === 1'b1) found = 1'b1;
      end
      expFlat = flatQ.pop_front();
      vecCount++;
      if (!found) begin
         missCount++;
         $display("[TB] FAIL %s_timeout: swap_done stayed 0, expected a pulse", name);
      end else if (coef_flat !== expFlat) begin
         missCount++;
         $display("[TB] FAIL %s_taps: tap %0d got %h expected %h", name, firstDiffTap(coef_flat, expFlat),
                  coef_flat[firstDiffTap(coef_flat, expFlat)*DW +: DW],
                  expFlat[firstDiffTap(coef_flat, expFlat)*DW +: DW]);
      end
      modelActive = expFlat;
      modelCnt++;
   endtask

   task automatic test_errors();
      logic [31:0] rd, exp;
      logic        err;
      applyStimulus(1'b1, 9'h100 + 9'd138, 32'h5555, 1'b0, rd, err);
      vecCount++;
      if (err !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL coef138_err: got %b expected 1", err);
      end
      rdQ.push_back(32'hFFFF8000);
      applyStimulus(1'b0, 9'h100 + 9'd137, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp || err !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL coef138_nochange: got %h err %b expected %h err 0", rd, err, exp);
      end
      rdQ.push_back(32'h0);
      applyStimulus(1'b0, 9'h050, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp || err !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL unmapped_read: got %h err %b expected %h err 1", rd, err, exp);
      end
      applyStimulus(1'b1, 9'h001, 32'hFFFF, 1'b0, rd, err);
      rdQ.push_back(statusWord(1'b0));
      applyStimulus(1'b0, 9'h001, 32'h0, 1'b0, rd, exp);
      exp = rdQ.pop_front();
      vecCount++;
      if (err !== 1'b0 || rd !== exp) begin
         missCount++;
         $display("[TB] FAIL status_write: err %b status %h expected err 0 status %h", err, rd, exp);
      end
      applyStimulus(1'b1, 9'h000, 32'h5, 1'b0, rd, err);
      flatQ.push_back(buildFlat());
      applyStimulus(1'b1, 9'h105, 32'h4444, 1'b0, rd, err);
      vecCount++;
      if (err !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL coef_wr_pending_err: got %b expected 1", err);
      end
      rdQ.push_back({{16{modelShadow[5][15]}}, modelShadow[5]});
      applyStimulus(1'b0, 9'h105, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp || err !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL coef5_unchanged: got %h err %b expected %h err 0", rd, err, exp);
      end
      pulseDecValid();
      waitCommit("errors");
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        err;
      applyStimulus(1'b1, 9'h102, 32'h0ABC, 1'b0, rd, err);
      modelShadow[2] = 16'h0ABC;
      applyStimulus(1'b1, 9'h000, 32'h5, 1'b1, rd, err);
      flatQ.push_back(buildFlat());
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         vecCount++;
         if (coef_flat !== modelActive || swap_done !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL coincident_nocommit_c%0d: diff tap %0d swap_done %b expected none",
                     c, firstDiffTap(coef_flat, modelActive), swap_done);
         end
      end
      pulseDecValid();
      waitCommit("coincident");
   endtask

   task automatic test_wrap();
      logic [31:0] rd, exp;
      logic        err;
      for (int i = 0; i < 256; i++) begin
         flatQ.push_back(buildFlat());
         applyStimulus(1'b1, 9'h000, 32'h4, 1'b0, rd, err);
         waitCommit("wrap");
         if (modelCnt == 8'hFF || modelCnt == 8'h00) begin
            rdQ.push_back(statusWord(1'b0));
            applyStimulus(1'b0, 9'h001, 32'h0, 1'b0, rd, err);
            exp = rdQ.pop_front();
            vecCount++;
            if (rd !== exp) begin
               missCount++;
               $display("[TB] FAIL wrap_status: got %h expected %h", rd, exp);
            end
         end
      end
      rdQ.push_back(statusWord(1'b0));
      applyStimulus(1'b0, 9'h001, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL wrap_final: got %h expected %h", rd, exp);
      end
   endtask

   task automatic test_reset_mid_pending();
      logic [31:0] rd, exp;
      logic        err;
      applyStimulus(1'b1, 9'h000, 32'h5, 1'b0, rd, err);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      vecCount++;
      if (coef_flat !== '0 || swap_done !== 1'b0 || dec_en !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL midreset_outputs: tap %0d nonzero swap_done %b en %b expected all 0",
                  firstDiffTap(coef_flat, '0), swap_done, dec_en);
      end
      @(posedge CLK); #1;
      RST = 1'b1;
      modelReset();
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         vecCount++;
         if (swap_done !== 1'b0 || coef_flat !== '0) begin
            missCount++;
            $display("[TB] FAIL midreset_quiet_c%0d: swap_done %b tap %0d nonzero expected 0",
                     c, swap_done, firstDiffTap(coef_flat, '0));
         end
      end
      rdQ.push_back(statusWord(1'b0));
      applyStimulus(1'b0, 9'h001, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL midreset_status: got %h expected %h", rd, exp);
      end
      rdQ.push_back(32'h0);
      applyStimulus(1'b0, 9'h100, 32'h0, 1'b0, rd, err);
      exp = rdQ.pop_front();
      vecCount++;
      if (rd !== exp) begin
         missCount++;
         $display("[TB] FAIL midreset_shadow: got %h expected %h", rd, exp);
      end
   endtask

   initial begin
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = '0;
      bus.pwdata  = '0;
      test_reset();
      test_ctrl_rw();
      test_deferred_commit();
      test_immediate_commit();
      test_errors();
      test_back_to_back();
      test_wrap();
      test_reset_mid_pending();
      vecCount++;
      if (flatQ.size() !== 0) begin
         missCount++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", flatQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
